mm_mem_access: RTL
==================

# mm_mem_access

Memory-access stage controller between the EX/MM pipeline register and the MM/WB register of the pipelined processor. It decodes the memory opcode held in EX/MM and runs a request/acknowledge transaction to a variable-latency data memory. While the access is outstanding it stalls the upstream pipeline. It formats load data (byte/half/word, sign or zero extension) into a held result register that feeds the MM/WB stage, and it reports misaligned and timed-out accesses.

## Interface
- TIMEOUT, 255: cycles in BUSY without `mem_ack` before the access is abandoned; legal range 1..65535.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode_ex_mm  in  6  MIPS opcode from EX/MM
- data_out_alu_ex_mm  in  32  effective byte address from EX/MM
- store_data_ex_mm  in  32  rt value for stores
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] forced to 0
- mem_be  out  4  byte enables; bit n covers lane n (bits 8n+7:8n)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with `mem_ack`
- mem_ack  in  1  one-cycle completion pulse
- data_out_mem  out  32  formatted load result, held until next load completes
- mm_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MM
- mem_fault  out  1  one-cycle fault pulse
- fault_addr  out  32  byte address of the most recent fault

## Operation
- Memory ops:
  - lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25
  - sb 0x28, sh 0x29, sw 0x2B
  - Every other opcode is a non-memory op.
- Byte order is little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Misaligned accesses: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned memory op present: mm_stall=1 (combinational); capture address, byte enables, wdata and opcode; next state BUSY.
  - IDLE, misaligned op present: no request, no stall; register mem_fault=1 for the next cycle; fault_addr ← address; stay IDLE. The op continues down the pipe as a nop to memory.
  - BUSY: mem_req=1 and mm_stall=1. All mem_* outputs are held stable. The timeout counter increments each cycle.
    - On mem_ack: a load writes its formatted result to data_out_mem; next state DONE.
    - When the counter reaches TIMEOUT without ack: mem_fault pulse, fault_addr ← captured address, data_out_mem unchanged; next state DONE.
  - DONE: mm_stall=0 for exactly one cycle so EX/MM advances; counter cleared; next state IDLE. The op present in DONE is not re-issued.
- Load formatting:
  - lb/lbu: selected byte, sign- or zero-extended.
  - lh/lhu: selected half, sign- or zero-extended.
  - lw: full word.
- Stores:
  - mem_be: sb → 4'b0001<<addr[1:0]; sh → 4'b0011<<(2·addr[1]); sw → 4'b1111.
  - mem_wdata: the byte or half is replicated across all lanes; a word is passed unmodified.
- mem_ack while in IDLE or DONE is ignored.
- The result is held because MM/WB passes data_out_mem through combinationally during writeback.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, counter 0
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
  - data_out_mem=0, mem_fault=0, fault_addr=0
  - mm_stall=0 while no memory op is present
- Reset during BUSY drops mem_req in the same instant. A late ack after reset is ignored.
- Cycle sequence:
  - Op in IDLE at cycle 0.
  - mem_req rises at cycle 1.
  - Ack at cycle k (k≥1) → DONE at cycle k+1, EX/MM advances at the end of k+1.
  - Stall cycles = k+1; minimum 2.
- data_out_mem updates on the edge ending the ack cycle. It is stable through the following WB cycle, because the next load cannot complete for at least 2 cycles.
- A timeout is declared in the cycle where count = TIMEOUT. mem_req is low from the next cycle.
- Back-to-back memory ops: DONE → IDLE → BUSY, with no idle gap beyond the DONE cycle.

## Test plan
- Reset check: assert rst_n=0 mid-BUSY → mem_req falls immediately and all outputs read 0. An ack arriving after reset release does not change data_out_mem.
- lw at 0x100, mem_rdata=0xDEADBEEF, ack at cycle 1 → mm_stall high for 2 cycles; data_out_mem=0xDEADBEEF; mem_be=4'hF; mem_addr=0x100.
- lb at 0x103 with rdata=0x80112233 → data_out_mem=0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x00008011.
- sb at 0x205 with store_data=0x000000A5, ack after 3 cycles → mem_be=4'b0010, mem_wdata=0xA5A5A5A5, mem_we=1, 4 stall cycles, data_out_mem unchanged.
- lw at 0x102 → no mem_req, no stall, mem_fault=1 for one cycle, fault_addr=0x102.
- TIMEOUT=4, sw with no ack → mem_req high for 4 cycles, then mem_fault pulse, then one DONE cycle with mm_stall=0.

Source files
------------

// File: rtl/mm_mem_access_if.sv
// rtl/mm_mem_access_if.sv - request/acknowledge data-memory bus between MM stage and memory
interface mm_mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mm_mem_access.sv
// rtl/mm_mem_access.sv - memory-access stage controller with variable-latency request/ack bus
module mm_mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode_ex_mm,
  input  logic [31:0]     data_out_alu_ex_mm,
  input  logic [31:0]     store_data_ex_mm,
  mm_mem_access_if.master mem,
  output logic [31:0]     data_out_mem,
  output logic            mm_stall,
  output logic            mem_fault,
  output logic [31:0]     fault_addr
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // size: 0 = byte, 1 = half, 2 = word
  typedef struct packed {
    logic       load;
    logic       store;
    logic       sext;
    logic [1:0] size;
  } op_t;

  function automatic op_t decode(input logic [5:0] op);
    op_t d;
    d = '0;
    case (op)
      6'h20: begin d.load = 1'b1; d.sext = 1'b1; d.size = 2'd0; end
      6'h21: begin d.load = 1'b1; d.sext = 1'b1; d.size = 2'd1; end
      6'h23: begin d.load = 1'b1; d.size = 2'd2; end
      6'h24: begin d.load = 1'b1; d.size = 2'd0; end
      6'h25: begin d.load = 1'b1; d.size = 2'd1; end
      6'h28: begin d.store = 1'b1; d.size = 2'd0; end
      6'h29: begin d.store = 1'b1; d.size = 2'd1; end
      6'h2B: begin d.store = 1'b1; d.size = 2'd2; end
      default: ;
    endcase
    return d;
  endfunction

  state_t      state, state_n;
  op_t         dec, op_q;
  logic [31:0] addr_q, wdata_q, wdata_n, load_val;
  logic [3:0]  be_q, be_n;
  logic [15:0] cnt;
  logic        is_mem, misaligned;
  logic        capture, fault_misalign, timeout, load_wr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    dec    = decode(opcode_ex_mm);
    is_mem = dec.load | dec.store;
    case (dec.size)
      2'd0: begin
        misaligned = 1'b0;
        be_n       = 4'b0001 << data_out_alu_ex_mm[1:0];
        wdata_n    = {4{store_data_ex_mm[7:0]}};
      end
      2'd1: begin
        misaligned = data_out_alu_ex_mm[0];
        be_n       = data_out_alu_ex_mm[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{store_data_ex_mm[15:0]}};
      end
      default: begin
        misaligned = |data_out_alu_ex_mm[1:0];
        be_n       = 4'b1111;
        wdata_n    = store_data_ex_mm;
      end
    endcase
  end

  // Lane selection uses the captured byte address; memory only sees the word address.
  always_comb begin
    byte_sel = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (op_q.size)
      2'd0:    load_val = {{24{op_q.sext & byte_sel[7]}}, byte_sel};
      2'd1:    load_val = {{16{op_q.sext & half_sel[15]}}, half_sel};
      default: load_val = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    mm_stall       = 1'b0;
    capture        = 1'b0;
    fault_misalign = 1'b0;
    timeout        = 1'b0;
    load_wr        = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            fault_misalign = 1'b1;
          end else begin
            mm_stall = 1'b1;
            capture  = 1'b1;
            state_n  = BUSY;
          end
        end
      end
      BUSY: begin
        mm_stall = 1'b1;
        if (mem.mem_ack) begin
          load_wr = op_q.load;
          state_n = DONE;
        end else if (cnt == 16'(TIMEOUT)) begin
          timeout = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      data_out_mem <= '0;
      mem_fault    <= 1'b0;
      fault_addr   <= '0;
    end else begin
      mem_fault <= fault_misalign | timeout;
      if (capture) begin
        op_q    <= dec;
        addr_q  <= data_out_alu_ex_mm;
        be_q    <= be_n;
        wdata_q <= wdata_n;
      end
      // The counter holds the number of the current BUSY cycle, starting at 1.
      if (capture) begin
        cnt <= 16'd1;
      end else if (state == BUSY) begin
        cnt <= cnt + 16'd1;
      end else begin
        cnt <= '0;
      end
      if (load_wr) begin
        data_out_mem <= load_val;
      end
      if (fault_misalign) begin
        fault_addr <= data_out_alu_ex_mm;
      end else if (timeout) begin
        fault_addr <= addr_q;
      end
    end
  end

  assign mem.mem_req   = (state == BUSY);
  assign mem.mem_we    = op_q.store;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
endmodule
